// File: rtl/mu0_pkg.sv
// Shared types and encodings for the MU0 control unit: state encoding, opcodes,
// ALU function codes, operand/address select values and the control-word struct.
package mu0_pkg;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StExecute = 2'd1,
    StHalt    = 2'd2
  } state_e;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASS_Y = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;
  localparam logic [1:0] ALU_INC    = 2'b11;

  localparam logic SEL_PC = 1'b0;
  localparam logic SEL_IR = 1'b1;
  localparam logic X_ACC  = 1'b0;
  localparam logic X_PC   = 1'b1;
  localparam logic Y_MEM  = 1'b0;
  localparam logic Y_IR   = 1'b1;

  typedef struct packed {
    logic       addr_sel;
    logic       x_sel;
    logic       y_sel;
    logic [1:0] alu_fs;
    logic       pc_en;
    logic       acc_en;
    logic       ir_en;
    logic       rd;
    logic       wr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Fetch reads the instruction at PC into IR and bumps PC in the same cycle.
  function automatic ctrl_t fetch_ctrl();
    ctrl_t c;
    c          = CTRL_IDLE;
    c.addr_sel = SEL_PC;
    c.rd       = 1'b1;
    c.ir_en    = 1'b1;
    c.x_sel    = X_PC;
    c.alu_fs   = ALU_INC;
    c.pc_en    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mu0_ctrl_decode.sv
// Combinational execute-phase decode: opcode plus Acc flags -> control word.
module mu0_ctrl_decode
  import mu0_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0] i_f,
  input  logic                i_n,
  input  logic                i_z,
  output ctrl_t               o_ctrl,
  output logic                o_stop
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    o_stop = 1'b0;
    case (i_f)
      OP_WIDTH'(OP_LDA): begin
        o_ctrl.addr_sel = SEL_IR;
        o_ctrl.rd       = 1'b1;
        o_ctrl.y_sel    = Y_MEM;
        o_ctrl.alu_fs   = ALU_PASS_Y;
        o_ctrl.acc_en   = 1'b1;
      end
      OP_WIDTH'(OP_STA): begin
        o_ctrl.addr_sel = SEL_IR;
        o_ctrl.wr       = 1'b1;
      end
      OP_WIDTH'(OP_ADD): begin
        o_ctrl.addr_sel = SEL_IR;
        o_ctrl.rd       = 1'b1;
        o_ctrl.x_sel    = X_ACC;
        o_ctrl.y_sel    = Y_MEM;
        o_ctrl.alu_fs   = ALU_ADD;
        o_ctrl.acc_en   = 1'b1;
      end
      OP_WIDTH'(OP_SUB): begin
        o_ctrl.addr_sel = SEL_IR;
        o_ctrl.rd       = 1'b1;
        o_ctrl.x_sel    = X_ACC;
        o_ctrl.y_sel    = Y_MEM;
        o_ctrl.alu_fs   = ALU_SUB;
        o_ctrl.acc_en   = 1'b1;
      end
      OP_WIDTH'(OP_JMP): begin
        o_ctrl.y_sel  = Y_IR;
        o_ctrl.alu_fs = ALU_PASS_Y;
        o_ctrl.pc_en  = 1'b1;
      end
      OP_WIDTH'(OP_JGE): begin
        o_ctrl.y_sel  = Y_IR;
        o_ctrl.alu_fs = ALU_PASS_Y;
        o_ctrl.pc_en  = ~i_n;
      end
      OP_WIDTH'(OP_JNE): begin
        o_ctrl.y_sel  = Y_IR;
        o_ctrl.alu_fs = ALU_PASS_Y;
        o_ctrl.pc_en  = ~i_z;
      end
      OP_WIDTH'(OP_STP): begin
        o_stop = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_ctrl_fsm.sv
// MU0 control unit: fetch/execute/halt sequencer with retired-instruction counter.
// Define MU0_WAIT_EN to add the Mem_Rdy wait-state input.
module mu0_ctrl_fsm
  import mu0_pkg::*;
#(
  parameter int unsigned OP_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
`ifdef MU0_WAIT_EN
  input  logic                 Mem_Rdy,
`endif
  input  logic [OP_WIDTH-1:0]  F,
  input  logic                 N,
  input  logic                 Z,
  output logic                 Addr_sel,
  output logic                 X_sel,
  output logic                 Y_sel,
  output logic [1:0]           ALU_FS,
  output logic                 PC_En,
  output logic                 Acc_En,
  output logic                 IR_En,
  output logic                 Rd,
  output logic                 Wr,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] Instr_Cnt
);

  state_e               r_state;
  state_e               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  ctrl_t                w_exec_ctrl;
  ctrl_t                w_ctrl;
  logic                 w_stop;
  logic                 w_halted;
  logic                 w_stall;

  mu0_ctrl_decode #(
    .OP_WIDTH(OP_WIDTH)
  ) u_decode (
    .i_f   (F),
    .i_n   (N),
    .i_z   (Z),
    .o_ctrl(w_exec_ctrl),
    .o_stop(w_stop)
  );

  always_comb begin
    w_ctrl   = CTRL_IDLE;
    w_halted = 1'b0;
    case (r_state)
      StFetch:   w_ctrl   = fetch_ctrl();
      StExecute: w_ctrl   = w_exec_ctrl;
      StHalt:    w_halted = 1'b1;
      default:   ;
    endcase
    if (Reset) begin
      w_ctrl   = CTRL_IDLE;
      w_halted = 1'b0;
    end
  end

`ifdef MU0_WAIT_EN
  // An access not yet acknowledged freezes the sequencer but keeps the bus driven.
  assign w_stall = (w_ctrl.rd | w_ctrl.wr) & ~Mem_Rdy;
`else
  assign w_stall = 1'b0;
`endif

  assign Addr_sel  = w_ctrl.addr_sel;
  assign X_sel     = w_ctrl.x_sel;
  assign Y_sel     = w_ctrl.y_sel;
  assign ALU_FS    = w_ctrl.alu_fs;
  assign Rd        = w_ctrl.rd;
  assign Wr        = w_ctrl.wr;
  assign PC_En     = w_ctrl.pc_en & ~w_stall;
  assign Acc_En    = w_ctrl.acc_en & ~w_stall;
  assign IR_En     = w_ctrl.ir_en & ~w_stall;
  assign Halted    = w_halted;
  assign Instr_Cnt = r_cnt;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!w_stall) begin
      case (r_state)
        StFetch: w_state_next = StExecute;
        StExecute: begin
          w_cnt_next   = r_cnt + CNT_WIDTH'(1);
          w_state_next = w_stop ? StHalt : StFetch;
        end
        StHalt:  w_state_next = StHalt;
        default: w_state_next = StFetch;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StFetch;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_mu0_ctrl_fsm.sv
// Self-checking bench for mu0_ctrl_fsm: directed program plus random opcodes
// checked against a cycle-level instruction model.
module tb_mu0_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  F;
  logic        N, Z;
`ifdef MU0_WAIT_EN
  logic        Mem_Rdy;
`endif
  logic        Addr_sel, X_sel, Y_sel, PC_En, Acc_En, IR_En, Rd, Wr, Halted;
  logic [1:0]  ALU_FS;
  logic [15:0] Instr_Cnt;

  logic        r4;
  logic [3:0]  f4;
  logic [3:0]  cnt4;
  logic        d_a, d_x, d_y, d_pc, d_acc, d_ir, d_rd, d_wr, d_h;
  logic [1:0]  d_fs;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: where we are in the instruction (fetch vs execute), halt, retired count.
  bit          m_exec;
  bit          m_halted;
  int unsigned m_cnt;

  always #5 Clk = ~Clk;

  mu0_ctrl_fsm dut (
    .Clk      (Clk),
    .Reset    (Reset),
`ifdef MU0_WAIT_EN
    .Mem_Rdy  (Mem_Rdy),
`endif
    .F        (F),
    .N        (N),
    .Z        (Z),
    .Addr_sel (Addr_sel),
    .X_sel    (X_sel),
    .Y_sel    (Y_sel),
    .ALU_FS   (ALU_FS),
    .PC_En    (PC_En),
    .Acc_En   (Acc_En),
    .IR_En    (IR_En),
    .Rd       (Rd),
    .Wr       (Wr),
    .Halted   (Halted),
    .Instr_Cnt(Instr_Cnt)
  );

  mu0_ctrl_fsm #(
    .CNT_WIDTH(4)
  ) dut4 (
    .Clk      (Clk),
    .Reset    (r4),
`ifdef MU0_WAIT_EN
    .Mem_Rdy  (1'b1),
`endif
    .F        (f4),
    .N        (1'b0),
    .Z        (1'b0),
    .Addr_sel (d_a),
    .X_sel    (d_x),
    .Y_sel    (d_y),
    .ALU_FS   (d_fs),
    .PC_En    (d_pc),
    .Acc_En   (d_acc),
    .IR_En    (d_ir),
    .Rd       (d_rd),
    .Wr       (d_wr),
    .Halted   (d_h),
    .Instr_Cnt(cnt4)
  );

  // Bit order: {addr, x, y, fs[1:0], pc_en, acc_en, ir_en, rd, wr, halted}
  function automatic logic [10:0] base_out();
    logic a, xs, ys, pc, acc, ir, rd, wr, hl;
    logic [1:0] fs;
    {a, xs, ys, fs, pc, acc, ir, rd, wr, hl} = '0;
    if (Reset) return '0;
    if (m_halted) begin
      hl = 1'b1;
    end else if (!m_exec) begin
      rd = 1'b1; ir = 1'b1; xs = 1'b1; fs = 2'd3; pc = 1'b1;
    end else begin
      case (F)
        4'd0: begin a = 1'b1; rd = 1'b1; acc = 1'b1; end
        4'd1: begin a = 1'b1; wr = 1'b1; end
        4'd2: begin a = 1'b1; rd = 1'b1; fs = 2'd1; acc = 1'b1; end
        4'd3: begin a = 1'b1; rd = 1'b1; fs = 2'd2; acc = 1'b1; end
        4'd4: begin ys = 1'b1; pc = 1'b1; end
        4'd5: begin ys = 1'b1; pc = !N; end
        4'd6: begin ys = 1'b1; pc = !Z; end
        default: ;
      endcase
    end
    return {a, xs, ys, fs, pc, acc, ir, rd, wr, hl};
  endfunction

  function automatic bit model_stall();
    logic [10:0] b;
    b = base_out();
`ifdef MU0_WAIT_EN
    return (b[2] | b[1]) && !Mem_Rdy;
`else
    return b[0] && 1'b0;
`endif
  endfunction

  function automatic logic [10:0] model_out();
    logic [10:0] b;
    b = base_out();
    if (model_stall()) b[5:3] = 3'b000;
    return b;
  endfunction

  task automatic model_step();
    if (Reset) begin
      m_exec = 1'b0; m_halted = 1'b0; m_cnt = 0;
    end else if (!model_stall() && !m_halted) begin
      if (!m_exec) begin
        m_exec = 1'b1;
      end else begin
        m_cnt    = m_cnt + 1;
        m_exec   = 1'b0;
        m_halted = (F == 4'd7);
      end
    end
  endtask

  task automatic check_model(string tag);
    logic [10:0] obs, exp;
    obs = {Addr_sel, X_sel, Y_sel, ALU_FS, PC_En, Acc_En, IR_En, Rd, Wr, Halted};
    exp = model_out();
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, obs, exp);
    end
    n_checks++;
    assert (Instr_Cnt === m_cnt[15:0]) else begin
      n_fail++;
      $error("FAIL %s cnt: observed %0d expected %0d", tag, Instr_Cnt, m_cnt[15:0]);
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model on the rising edge.
  task automatic tick(string tag);
    @(negedge Clk);
    check_model(tag);
    @(posedge Clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [3:0] ops [4];
    logic [3:0] jf  [4];
    logic       jn  [4];
    logic       jz  [4];
    logic       jpc [4];
    ops = '{4'd0, 4'd2, 4'd3, 4'd1};
    jf  = '{4'd5, 4'd5, 4'd6, 4'd6};
    jn  = '{1'b1, 1'b0, 1'b0, 1'b0};
    jz  = '{1'b0, 1'b0, 1'b1, 1'b0};
    jpc = '{1'b0, 1'b1, 1'b0, 1'b1};

    Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0;
    r4 = 1'b1; f4 = 4'd8;
`ifdef MU0_WAIT_EN
    Mem_Rdy = 1'b1;
`endif
    @(posedge Clk);
    model_step();
    #1;
    r4 = 1'b0;

    // Main DUT held in reset while the narrow counter instance runs 16 no-ops.
    repeat (30) tick("reset_hold");
    chk("cnt4_before_wrap", 16'(cnt4), 16'd15);
    repeat (2) tick("reset_hold");
    chk("cnt4_wrap", 16'(cnt4), 16'd0);

    Reset = 1'b0; F = 4'd0;
    #1;
    chk("fetch_addr_sel", 16'(Addr_sel), 16'd0);
    chk("fetch_rd", 16'(Rd), 16'd1);
    chk("fetch_ir_en", 16'(IR_En), 16'd1);
    chk("fetch_pc_en", 16'(PC_En), 16'd1);
    chk("fetch_alu_fs", 16'(ALU_FS), 16'd3);
    chk("fetch_cnt", Instr_Cnt, 16'd0);

    for (int i = 0; i < 4; i++) begin
      F = ops[i];
      tick("prog_fetch");
      chk("exec_addr_sel", 16'(Addr_sel), 16'd1);
      chk("exec_wr", 16'(Wr), 16'(ops[i] == 4'd1));
      tick("prog_exec");
    end
    chk("cnt_after_4", Instr_Cnt, 16'd4);

    for (int i = 0; i < 4; i++) begin
      F = jf[i]; N = jn[i]; Z = jz[i];
      tick("jump_fetch");
      chk("jump_pc_en", 16'(PC_En), 16'(jpc[i]));
      chk("jump_y_sel", 16'(Y_sel), 16'd1);
      tick("jump_exec");
    end

    F = 4'd7;
    tick("stp_fetch");
    tick("stp_exec");
    for (int i = 0; i < 10; i++) begin
      F = 4'($urandom_range(0, 15));
      #1;
      chk("halted", 16'(Halted), 16'd1);
      chk("halt_cnt", Instr_Cnt, 16'd9);
      tick("halt");
    end

    Reset = 1'b1;
    tick("reset_from_halt");
    Reset = 1'b0; F = 4'd2;
    #1;
    chk("post_reset_rd", 16'(Rd), 16'd1);
    chk("post_reset_cnt", Instr_Cnt, 16'd0);
    chk("post_reset_halted", 16'(Halted), 16'd0);

`ifdef MU0_WAIT_EN
    Mem_Rdy = 1'b0; F = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_rd", 16'(Rd), 16'd1);
      chk("wait_addr", 16'(Addr_sel), 16'd0);
      chk("wait_ir_en", 16'(IR_En), 16'd0);
      chk("wait_pc_en", 16'(PC_En), 16'd0);
      tick("wait_fetch");
    end
    Mem_Rdy = 1'b1;
    #1;
    chk("ready_ir_en", 16'(IR_En), 16'd1);
    chk("ready_pc_en", 16'(PC_En), 16'd1);
    tick("ready_fetch");
    chk("ready_exec_addr", 16'(Addr_sel), 16'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 29) == 0);
      F     = 4'($urandom_range(0, 15));
      N     = 1'($urandom_range(0, 1));
      Z     = 1'($urandom_range(0, 1));
`ifdef MU0_WAIT_EN
      Mem_Rdy = ($urandom_range(0, 3) != 0);
`endif
      tick("random");
      n_checks++;
      assert (!(Rd && Wr)) else begin
        n_fail++;
        $error("FAIL rd_wr_exclusive: observed rd=%b wr=%b expected not both", Rd, Wr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
